// File: rtl/dual_port_ram_hs.sv
// dual_port_ram_hs: dual-port RAM with valid/ready write and read ports,
// per-byte write enables and a 2-entry read-response buffer.
// After each reset a sequencer clears every word before the ports open.
// Optional feature macro: DPRAM_BYPASS_EN (write-first on same-cycle,
// same-address collisions; read-first when undefined).
module dual_port_ram_hs #(
    parameter int MEM_DEPTH  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    init_done
);
    localparam int NB = DATA_WIDTH / 8;
    // One extra bit so the range check also works when 2**ADDR_WIDTH == MEM_DEPTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   resp [2];
    logic [1:0]              count;
    logic                    wr_fire, rd_fire, pop;
    logic                    wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign wr_fire     = wr_valid && wr_ready;
    assign rd_fire     = rd_valid && rd_ready;
    assign pop         = rdata_valid && rdata_ready;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign rdata_valid = (count != 2'd0);
    assign rdata       = resp[0];

    // State register: reset always restarts the clearing sequence.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_INIT;
        else      state <= state_nxt;
    end

    // Next state and port-open outputs; ports stay closed until clearing ends.
    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        init_done = 1'b0;
        case (state)
            S_INIT: if (clr_cnt == LAST_ADDR) state_nxt = S_RUN;
            S_RUN: begin
                wr_ready  = 1'b1;
                rd_ready  = (count != 2'd2);
                init_done = 1'b1;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Clear counter walks the array once per reset.
    always_ff @(posedge clk) begin
        if (!rst)                 clr_cnt <= '0;
        else if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
    end

    // Read word: out-of-range returns zero; a colliding write may be merged in.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[rd_addr];
`ifdef DPRAM_BYPASS_EN
        if (wr_fire && wr_in_range && rd_in_range && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
`endif
    end

    // Array write: clearing during INIT, byte-masked writes in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_INIT) begin
                mem[clr_cnt] <= '0;
            end else if (wr_fire && wr_in_range) begin
                for (int b = 0; b < NB; b++)
                    if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Response buffer: entry 0 is the head; pushes append, pops shift down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= 2'd0;
            resp[0] <= '0;
            resp[1] <= '0;
        end else begin
            case ({rd_fire, pop})
                2'b10: begin
                    if (count == 2'd0) resp[0] <= rd_word;
                    else               resp[1] <= rd_word;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    resp[0] <= resp[1];
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        resp[0] <= rd_word;
                    end else begin
                        resp[0] <= resp[1];
                        resp[1] <= rd_word;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_port_ram_hs.sv
// Scoreboard bench for dual_port_ram_hs (12 x 16-bit build, so out-of-range
// addresses and per-byte merges are reachable). Driver pushes expected
// responses from an array model; a negedge monitor pops and compares.
module tb_dual_port_ram_hs;
    localparam int DEPTH = 12;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;

    logic          clk, rst;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rdata;
    logic [NB-1:0] wr_be;
    logic          rdata_valid, rdata_ready, init_done;

    int vectors = 0;
    int miscompares = 0;
    bit run = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] q [$];
    bit            stalled = 0;
    logic [DW-1:0] held;

    dual_port_ram_hs #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        if (32'(a) < DEPTH) return model[a];
        return '0;
    endfunction

    // One clock of stimulus, called at posedge+1; acceptance follows the
    // bench's own view of when each port must be open.
    task automatic cycle(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] wbe, input bit rv, input logic [AW-1:0] ra);
        bit wacc, racc, rexp;
        logic [DW-1:0] e;
        rexp = run && (q.size() < 2);
        check("wr_ready", 32'(wr_ready), 32'(run));
        check("rd_ready", 32'(rd_ready), 32'(rexp));
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_valid = rv; rd_addr = ra;
        wacc = wv && run;
        racc = rv && rexp;
        if (racc) begin
            e = mread(ra);
`ifdef DPRAM_BYPASS_EN
            if (wacc && wa == ra && 32'(ra) < DEPTH) e = merge(e, wd, wbe);
`endif
            q.push_back(e);
        end
        if (wacc && 32'(wa) < DEPTH) model[wa] = merge(model[wa], wd, wbe);
        @(posedge clk); #1;
        wr_valid = 0; rd_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0);
    endtask

    task automatic drain();
        rdata_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Reset (optionally with a write presented that must be dropped), then
    // poll the clearing sequence cycle by cycle.
    task automatic do_reset(input bit junk_write);
        rst = 0; run = 0; rd_valid = 0; rdata_ready = 0;
        wr_valid = junk_write; wr_addr = '0; wr_data = '1; wr_be = '1;
        q.delete();
        @(posedge clk); #1;
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1; wr_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            check("init_busy", 32'({init_done, wr_ready, rd_ready}), 32'd0);
            @(posedge clk); #1;
        end
        check("init_done", 32'({init_done, wr_ready, rd_ready}), 32'd7);
        run = 1;
    endtask

    task automatic readback_all();
        rdata_ready = 1;
        for (int a = 0; a < DEPTH; a++) cycle(0, '0, '0, '0, 1, AW'(a));
        drain();
    endtask

    // Monitor: compare each popped response and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            stalled = 0;
        end else begin
            if (stalled && rdata_valid === 1'b1) check("stall_hold", 32'(rdata), 32'(held));
            if (rdata_valid === 1'b1 && rdata_ready) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL spurious_rdata: got %0h expected no response", rdata);
                end else begin
                    check("rdata", 32'(rdata), 32'(q.pop_front()));
                end
            end
            stalled = (rdata_valid === 1'b1) && !rdata_ready;
            held = rdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 0; rst = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_valid = 0; rd_addr = '0; rdata_ready = 0;
        @(posedge clk); #1;
        do_reset(0);
        readback_all();

        // Full write, masked no-op write, partial write, out-of-range.
        rdata_ready = 1;
        cycle(1, 4'd3, 16'hA5A5, 2'b11, 0, '0);
        cycle(0, '0, '0, '0, 1, 4'd3);
        cycle(1, 4'd3, 16'h3C3C, 2'b00, 0, '0);
        cycle(0, '0, '0, '0, 1, 4'd3);
        cycle(1, 4'd3, 16'h0077, 2'b01, 0, '0);
        cycle(0, '0, '0, '0, 1, 4'd3);
        cycle(1, 4'd13, 16'hDEAD, 2'b11, 1, 4'd13);
        cycle(0, '0, '0, '0, 1, 4'd13);
        cycle(0, '0, '0, '0, 1, 4'd3);
        drain();

        // Backpressure: two accepted, third refused, reopen after first pop.
        cycle(1, 4'd1, 16'h0101, 2'b11, 0, '0);
        cycle(1, 4'd2, 16'h0202, 2'b11, 0, '0);
        cycle(1, 4'd3, 16'h0303, 2'b11, 0, '0);
        rdata_ready = 0;
        cycle(0, '0, '0, '0, 1, 4'd1);
        cycle(0, '0, '0, '0, 1, 4'd2);
        check("bp_full", 32'(rd_ready), 32'd0);
        cycle(0, '0, '0, '0, 1, 4'd3);
        idle(3);
        rdata_ready = 1;
        idle(1);
        check("bp_reopen", 32'(rd_ready), 32'd1);
        cycle(0, '0, '0, '0, 1, 4'd3);
        drain();

        // Same-cycle, same-address collisions (full and partial masks).
        cycle(1, 4'd5, 16'h1111, 2'b11, 0, '0);
        cycle(1, 4'd5, 16'h2222, 2'b11, 1, 4'd5);
        cycle(1, 4'd5, 16'h3344, 2'b01, 1, 4'd5);
        cycle(0, '0, '0, '0, 1, 4'd5);
        drain();

        // Streaming: write i while reading i-1 every cycle.
        for (int i = 1; i < DEPTH; i++)
            cycle(1, AW'(i), DW'(i * 16'h0123), 2'b11, 1, AW'(i - 1));
        drain();

        // Reset with two responses buffered and a write presented.
        rdata_ready = 0;
        cycle(1, 4'd0, 16'hBEEF, 2'b11, 1, 4'd1);
        cycle(1, 4'd2, 16'hCAFE, 2'b11, 1, 4'd2);
        check("pre_rst_full", 32'({rdata_valid, rd_ready}), 32'd2);
        do_reset(1);
        readback_all();

        // Random concurrent traffic with toggling backpressure.
        for (int i = 0; i < 500; i++) begin
            rdata_ready = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                  NB'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
        end
        drain();
        readback_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_hs.md
# dual_port_ram_hs

Parametrised dual-port RAM with independent valid/ready write and read ports, per-byte write enables and a 2-entry read-response buffer that absorbs consumer backpressure. After every reset a hardware sequencer clears the whole array before either port is opened. It sits between bus-side producers/consumers and storage, replacing the single-valid, fixed 16x8 memory in the datapath.

## Interface

- MEM_DEPTH, 16, number of words (any value ≥ 2)
- DATA_WIDTH, 8, word width in bits (multiple of 8)
- ADDR_WIDTH, 4, address width; must satisfy 2**ADDR_WIDTH ≥ MEM_DEPTH

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write port can accept
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables, bit i covers wr_data[8i+7:8i]
- rd_valid  in  1  read request present
- rd_ready  out  1  read port can accept
- rd_addr  in  ADDR_WIDTH  read address
- rdata_valid  out  1  response at head of response buffer
- rdata_ready  in  1  consumer takes response
- rdata  out  DATA_WIDTH  response data
- init_done  out  1  array cleared, ports open

## Operation

- States: INIT, RUN. rst low at an edge forces INIT with clear counter 0, response buffer flushed, and any in-progress transfer dropped.
- INIT: each cycle writes 0 to mem[counter] and increments. The cycle that writes entry MEM_DEPTH-1 transitions to RUN. All entries including the last are cleared.
- RUN is held until the next reset. init_done is 1 in RUN only.
- Write accept: wr_valid && wr_ready. wr_ready = (state==RUN). Only bytes with wr_be set are updated. wr_be=0 is accepted as a no-op.
- Read accept: rd_valid && rd_ready. rd_ready = (state==RUN) && (buffer count < 2). On accept, mem[rd_addr] is pushed into the response buffer at the same edge.
- Pop: rdata_valid && rdata_ready. Push and pop in the same cycle leaves count unchanged.
- rdata is the buffer head. It is held stable while rdata_valid && !rdata_ready. Responses are returned in request order.
- Address ≥ MEM_DEPTH: a write is accepted and discarded; a read is accepted and returns 0.
- Simultaneous write and read to different addresses: both complete in the same cycle.
- Simultaneous write and read to the same address: behaviour is set by the Configuration section.

## Timing

- Reset values: wr_ready 0, rd_ready 0, rdata_valid 0, rdata 0, init_done 0.
- Init latency: reset deasserted before edge E0. Entries are cleared at edges E0..E(MEM_DEPTH-1). wr_ready, rd_ready and init_done are 1 from the cycle after E(MEM_DEPTH-1).
- Write latency 1: data accepted at edge N is readable by a read accepted at edge N+1.
- Read latency 1: read accepted at edge N gives rdata_valid=1 with data in the cycle after N.
- Throughput: one write plus one read per cycle while rdata_ready=1.
- Backpressure: with rdata_ready=0, exactly 2 reads are accepted, then rd_ready=0. rd_ready rises in the cycle after the first pop.
- rdata is don't-care while rdata_valid=0. It is never X after reset.

## Configuration

- DPRAM_BYPASS_EN defined: a same-cycle, same-address read returns the new data. Bytes with wr_be set take wr_data; the other bytes take the old memory value (write-first).
- DPRAM_BYPASS_EN undefined: a same-cycle, same-address read returns the pre-write contents (read-first). The new data is visible from the next accepted read.

## Test plan

- Reset, then poll: init_done=0 and both readies 0 for exactly 16 cycles, then 1. Reads of addresses 0..15 all return 0x00, including address 15.
- Write 0xA5 to address 3 with wr_be=1, then read address 3 → 0xA5. Write 0x3C to address 3 with wr_be=0, then read → 0xA5 unchanged. Read address 3 with MEM_DEPTH=12 and address 13 → 0x00.
- Hold rdata_ready=0 and issue reads of addresses 1, 2, 3 back to back: only 2 are accepted, rd_ready=0 on the third. Raise rdata_ready: responses appear in order (1, 2, 3) and rdata is stable while stalled.
- Preload address 5 with 0x11, then write 0x22 and read address 5 in the same cycle: the response is 0x11 without DPRAM_BYPASS_EN and 0x22 with it. With a multi-byte DATA_WIDTH and partial wr_be, the bypass response merges per byte.
- Assert rst low with 2 responses buffered and mid-stream writes in flight: rdata_valid=0 next cycle, buffer empty, INIT restarts, and all entries read back as 0 after init_done.
- Random streams of concurrent writes and reads with rdata_ready toggling, checked against a reference model: no lost, duplicated or reordered responses.
